avmm_mem_stream_master: RTL and testbench

- Avalon-MM host that drives the single-port on-chip memory slave.
- Accepts block commands (start address, length, direction):
  - WRITE commands move words from an input valid/ready stream into memory.
  - READ commands move words from memory to an output valid/ready stream.
- Sits between a loader/DMA-style client and the memory's s1 port. Sustains one word per cycle when the stream side allows it.

---
 rtl/avmm_mem_stream_pkg.sv | 25 ++
 rtl/avmm_mem_stream_fifo.sv | 84 ++++++++
 rtl/avmm_mem_stream_master.sv | 203 ++++++++++++++++++++
 tb/tb_avmm_mem_stream_master.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_mem_stream_pkg.sv
// Shared definitions for the Avalon-MM memory stream master.
//   - Default geometry constants for the memory slave.
//   - Command state encoding shared by the top and any debug tooling.
//   - fifo_depth(): read-return buffer depth for a given memory read latency.
package avmm_mem_stream_pkg;

    localparam int unsigned DEFAULT_AW           = 10;
    localparam int unsigned DEFAULT_DW           = 32;
    localparam int unsigned DEFAULT_READ_LATENCY = 1;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain,
        StDone
    } state_e;

    // The memory cannot be stalled, so every read in flight needs a reserved
    // slot. One extra slot lets a word be popped while the next one lands.
    function automatic int unsigned fifo_depth(input int unsigned read_latency);
        return read_latency + 1;
    endfunction

endpackage

// File: rtl/avmm_mem_stream_fifo.sv
// Small synchronous FIFO holding words returned by the memory on reads.
// Ports:
//   clk_i, reset_i  clock and synchronous active-high reset (clears contents)
//   push_i          write push_data_i at the tail (ignored when full without a pop)
//   push_data_i     data to enqueue
//   pop_i           remove the head word (ignored when empty)
//   head_o          current head word (valid while count_o != 0)
//   count_o         number of stored words
// A push and a pop in the same cycle are both honoured, including when full.
module avmm_mem_stream_fifo
    import avmm_mem_stream_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned DW    = DEFAULT_DW,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Pointer increment that also handles non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/avmm_mem_stream_master.sv
// Avalon-MM host for a single-port on-chip memory (s1 port), moving blocks of
// words between valid/ready streams and memory.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready                command handshake (accepted only in idle)
//   cmd_write, cmd_addr, cmd_len,      direction (1 = stream to memory), start word
//   cmd_byteenable                     address, word count (0 legal), write byteenable
//   wr_data/wr_valid/wr_ready          input stream feeding memory writes
//   rd_data/rd_valid/rd_ready          output stream carrying memory read data
//   busy, done                         command in progress, one-cycle completion pulse
//   address, byteenable, chipselect,   Avalon-MM host signals towards the memory
//   write, writedata, clken, readdata
// Writes are issued combinationally on the accepting stream cycle. Reads are
// issued only while a return slot is guaranteed, since readdata cannot stall.
module avmm_mem_stream_master
    import avmm_mem_stream_pkg::*;
#(
    parameter int unsigned AW           = DEFAULT_AW,
    parameter int unsigned DW           = DEFAULT_DW,
    parameter int unsigned BEW          = DW / 8,
    parameter int unsigned READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic           clk,
    input  logic           reset,
    // Command interface
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_write,
    input  logic [AW-1:0]  cmd_addr,
    input  logic [AW:0]    cmd_len,
    input  logic [BEW-1:0] cmd_byteenable,
    // Write stream
    input  logic [DW-1:0]  wr_data,
    input  logic           wr_valid,
    output logic           wr_ready,
    // Read stream
    output logic [DW-1:0]  rd_data,
    output logic           rd_valid,
    input  logic           rd_ready,
    // Status
    output logic           busy,
    output logic           done,
    // Avalon-MM host
    output logic [AW-1:0]  address,
    output logic [BEW-1:0] byteenable,
    output logic           chipselect,
    output logic           write,
    output logic [DW-1:0]  writedata,
    output logic           clken,
    input  logic [DW-1:0]  readdata
);

    localparam int unsigned FIFO_DEPTH = fifo_depth(READ_LATENCY);
    localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0] REM_ONE    = (AW + 1)'(1);

    state_e                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [AW:0]             rem_q, rem_d;
    logic [BEW-1:0]          be_q, be_d;
    // One bit per read in flight; the oldest bit marks readdata valid this cycle.
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;

    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    credit_ok;
    logic [CW-1:0]           fifo_count;
    int                      outstanding;

    avmm_mem_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk_i       (clk),
        .reset_i     (reset),
        .push_i      (push),
        .push_data_i (readdata),
        .pop_i       (pop),
        .head_o      (rd_data),
        .count_o     (fifo_count)
    );

    assign push     = pipe_q[READ_LATENCY-1];
    assign rd_valid = (fifo_count != '0) && !reset;
    assign pop      = rd_valid && rd_ready;

    always_comb begin
        outstanding = 0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            outstanding = outstanding + int'(pipe_q[i]);
        end
    end

    // A word popped this cycle frees its slot before the new read can return,
    // which keeps reads streaming at one word per cycle while rd_ready is high.
    assign credit_ok = (outstanding + int'(fifo_count)) < (int'(FIFO_DEPTH) + int'(pop));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        be_d       = be_q;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        issue      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    be_d   = cmd_byteenable;
                    if (cmd_len == '0) begin
                        state_d = StDone;
                    end else if (cmd_write) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StWrite: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    chipselect = 1'b1;
                    write      = 1'b1;
                    addr_d     = addr_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                    if (rem_q == REM_ONE) begin
                        state_d = StDone;
                    end
                end
            end
            StRead: begin
                if (credit_ok) begin
                    chipselect = 1'b1;
                    issue      = 1'b1;
                    addr_d     = addr_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                    if (rem_q == REM_ONE) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if ((outstanding == 0) && (fifo_count == '0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The memory must see no access from the reset cycle onward.
        if (reset) begin
            cmd_ready  = 1'b0;
            wr_ready   = 1'b0;
            chipselect = 1'b0;
            write      = 1'b0;
            issue      = 1'b0;
        end
    end

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            be_q    <= '0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            be_q    <= be_d;
            pipe_q  <= pipe_d;
        end
    end

    assign address    = reset ? '0 : addr_q;
    assign byteenable = (state_q == StWrite) ? be_q : '1;
    assign writedata  = wr_data;
    assign clken      = !reset;
    assign busy       = !reset && (state_q != StIdle);
    assign done       = !reset && (state_q == StDone);

endmodule

// File: tb/tb_avmm_mem_stream_master.sv
module tb_avmm_mem_stream_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [9:0]  cmd_addr;
    logic [10:0] cmd_len;
    logic [3:0]  cmd_byteenable;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        busy;
    logic        done;
    logic [9:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic        clken;
    logic [31:0] readdata;

    avmm_mem_stream_master dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_byteenable (cmd_byteenable),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .busy           (busy),
        .done           (done),
        .address        (address),
        .byteenable     (byteenable),
        .chipselect     (chipselect),
        .write          (write),
        .writedata      (writedata),
        .clken          (clken),
        .readdata       (readdata)
    );

    always #5 clk = ~clk;

    // On-chip memory slave, read latency 1.
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (clken && chipselect) begin
            if (write) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end else begin
                readdata <= mem[address];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [9:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_ev_t;

    wr_ev_t      wq[$];
    logic [31:0] rq[$];
    int          rq_c[$];
    int          cs_cnt, issued, popped, done_cnt, max_infl, credit_viol;

    always @(negedge clk) begin
        if (chipselect && !write && (issued - popped - ((rd_valid && rd_ready) ? 1 : 0)) >= 2)
            credit_viol++;
        if (chipselect) begin
            cs_cnt++;
            if (write) wq.push_back('{cyc, address, writedata, byteenable});
            else issued++;
        end
        if (rd_valid && rd_ready) begin
            rq.push_back(rd_data);
            rq_c.push_back(cyc);
            popped++;
        end
        if (done) done_cnt++;
        if (issued - popped > max_infl) max_infl = issued - popped;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete();
        rq.delete();
        rq_c.delete();
        cs_cnt = 0; issued = 0; popped = 0; done_cnt = 0; max_infl = 0; credit_viol = 0;
    endtask

    task automatic send_cmd(input logic w, input logic [9:0] a, input logic [10:0] l,
                            input logic [3:0] be, output int acc);
        cmd_valid      = 1'b1;
        cmd_write      = w;
        cmd_addr       = a;
        cmd_len        = l;
        cmd_byteenable = be;
        @(negedge clk);
        check("cmd_ready", cmd_ready, 1);
        acc = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    logic [31:0] wvec [16];

    task automatic push_words(input int n, input logic [3:0] vpat, input int budget);
        int  i = 0;
        int  k = 0;
        logic accd;
        while (i < n && k < budget) begin
            wr_valid = vpat[k % 4];
            wr_data  = wvec[i];
            @(negedge clk);
            accd = wr_valid && wr_ready;
            tick();
            if (accd) i++;
            k++;
        end
        wr_valid = 1'b0;
        check("push_beats", i, n);
    endtask

    task automatic wait_done(input logic [3:0] rpat, input int budget, output int dcyc);
        int k = 0;
        logic seen = 1'b0;
        dcyc = -1;
        while (!seen && k < budget) begin
            rd_ready = rpat[k % 4];
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
            end
            tick();
            k++;
        end
        rd_ready = 1'b0;
        check("done_seen", seen, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        tick();
    endtask

    logic [9:0] t1_addr [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [31:0] t5_rd  [4] = '{32'hC0DE1111, 32'hC0DEAAA0, 32'hC0DEAAA1, 32'hC0DEAAA2};

    initial begin
        int acc;
        int dcyc;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_byteenable = '0; wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        clear_mon();
        repeat (2) tick();

        // Reset values
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_clken", clken, 0);
        check("rst_chipselect", chipselect, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_ready", wr_ready, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_clken", clken, 1);
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        check("post_rst_address", address, 0);
        tick();

        // Write 4 words across the address wrap
        for (int i = 0; i < 4; i++) wvec[i] = 32'hA0 + i;
        clear_mon();
        send_cmd(1'b1, 10'h3FE, 11'd4, 4'hF, acc);
        push_words(4, 4'b1111, 20);
        wait_done(4'b1111, 20, dcyc);
        check("t1_nwr", wq.size(), 4);
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            check($sformatf("t1_addr%0d", i), wq[i].a, t1_addr[i]);
            check($sformatf("t1_data%0d", i), wq[i].d, 32'hA0 + i);
            check($sformatf("t1_be%0d", i), wq[i].be, 4'hF);
            check($sformatf("t1_cyc%0d", i), wq[i].c, acc + 1 + i);
        end
        check("t1_done_cyc", dcyc, acc + 5);
        check("t1_done_cnt", done_cnt, 1);

        // Read them back with rd_ready held high
        clear_mon();
        send_cmd(1'b0, 10'h3FE, 11'd4, 4'hF, acc);
        wait_done(4'b1111, 30, dcyc);
        check("t2_nrd", rq.size(), 4);
        for (int i = 0; i < 4 && i < rq.size(); i++) begin
            check($sformatf("t2_data%0d", i), rq[i], 32'hA0 + i);
            check($sformatf("t2_cyc%0d", i), rq_c[i], acc + 3 + i);
        end
        check("t2_done_cyc", dcyc, acc + 8);

        // Fill 8 words, then read with rd_ready pattern 1,0,0,1
        for (int i = 0; i < 8; i++) wvec[i] = 32'hC0DE0000 + i * 32'h1111;
        send_cmd(1'b1, 10'h100, 11'd8, 4'hF, acc);
        push_words(8, 4'b1111, 30);
        wait_done(4'b1111, 10, dcyc);
        clear_mon();
        send_cmd(1'b0, 10'h100, 11'd8, 4'hF, acc);
        wait_done(4'b1001, 200, dcyc);
        check("t3_nrd", rq.size(), 8);
        for (int i = 0; i < 8 && i < rq.size(); i++)
            check($sformatf("t3_data%0d", i), rq[i], 32'hC0DE0000 + i * 32'h1111);
        check("t3_issued", issued, 8);
        check("t3_max_inflight_le2", max_infl <= 2, 1);
        check("t3_credit_viol", credit_viol, 0);

        // Zero-length command
        clear_mon();
        send_cmd(1'b0, 10'h055, 11'd0, 4'hF, acc);
        wait_done(4'b1111, 10, dcyc);
        check("t4_done_cyc", dcyc, acc + 1);
        check("t4_no_cs", cs_cnt, 0);

        // Gappy write stream with partial byteenable
        for (int i = 0; i < 3; i++) wvec[i] = 32'hFFFFAAA0 + i;
        clear_mon();
        send_cmd(1'b1, 10'h102, 11'd3, 4'b0011, acc);
        push_words(3, 4'b0101, 20);
        wait_done(4'b1111, 10, dcyc);
        check("t5_cs_cnt", cs_cnt, 3);
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            check($sformatf("t5_be%0d", i), wq[i].be, 4'b0011);
            check($sformatf("t5_addr%0d", i), wq[i].a, 10'h102 + i);
            check($sformatf("t5_cyc%0d", i), wq[i].c, acc + 1 + 2 * i);
        end
        clear_mon();
        send_cmd(1'b0, 10'h101, 11'd4, 4'hF, acc);
        wait_done(4'b1111, 30, dcyc);
        check("t5_nrd", rq.size(), 4);
        for (int i = 0; i < 4 && i < rq.size(); i++)
            check($sformatf("t5_rdata%0d", i), rq[i], t5_rd[i]);

        // Reset in the middle of a read with two words in flight
        clear_mon();
        send_cmd(1'b0, 10'h100, 11'd8, 4'hF, acc);
        rd_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("t6_inflight", issued, 2);
        check("t6_rst_cs", chipselect, 0);
        check("t6_rst_cmd_ready", cmd_ready, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t6_cs", chipselect, 0);
        check("t6_rd_valid", rd_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        rd_ready = 1'b1;
        repeat (5) tick();
        rd_ready = 1'b0;
        check("t6_no_pops", popped, 0);
        check("t6_no_done", done_cnt, 0);
        clear_mon();
        send_cmd(1'b0, 10'h3FE, 11'd4, 4'hF, acc);
        wait_done(4'b1111, 30, dcyc);
        check("t6_nrd", rq.size(), 4);
        for (int i = 0; i < 4 && i < rq.size(); i++)
            check($sformatf("t6_data%0d", i), rq[i], 32'hA0 + i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
